// File: rtl/sqwave_pkg.sv
// Shared definitions for the square-wave measurement block and its generator.
package sqwave_pkg;

  localparam int unsigned HI_W_DEF        = 16;
  localparam int unsigned LO_W_DEF        = 10;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meas_state_e;

  // Width of a counter that has to hold either duration.
  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sqwave_meas_if.sv
// Measurement-path signals: waveform and enable in, durations and flags out.
interface sqwave_meas_if
  import sqwave_pkg::*;
#(
  parameter int unsigned HI_W = HI_W_DEF,
  parameter int unsigned LO_W = LO_W_DEF
) ();

  logic            sig_in;
  logic            meas_en;
  logic [HI_W-1:0] hi_count;
  logic [LO_W-1:0] lo_count;
  logic            meas_valid;
  logic            stuck_hi;
  logic            stuck_lo;
  logic            level;

  modport master (
    output sig_in, meas_en,
    input  hi_count, lo_count, meas_valid, stuck_hi, stuck_lo, level
  );

  modport slave (
    input  sig_in, meas_en,
    output hi_count, lo_count, meas_valid, stuck_hi, stuck_lo, level
  );

endinterface

// File: rtl/sync_edge_det.sv
// Synchronizer for an asynchronous level plus registered edge detection.
// s, rise and fall update on the same edge, so rise implies s==1 this cycle
// and s==0 the cycle before. STAGES must be at least 2.
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              s_d;

  // Synchronizer chain, delayed level and edge flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      s_d    <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~s_d;
      fall   <= ~sync_q[STAGES-1] & s_d;
    end
  end

  assign s = s_d;

endmodule

// File: rtl/sqwave_meas.sv
// Measures high and low durations of a square wave, one full period at a time.
// A period is reported on the rise that closes it; the edge cycle counts as
// cycle 1 of the new level.
module sqwave_meas
  import sqwave_pkg::*;
#(
  parameter int unsigned HI_W        = HI_W_DEF,
  parameter int unsigned LO_W        = LO_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  sqwave_meas_if.slave bus
);

  localparam int unsigned    CNT_W  = max_w(HI_W, LO_W);
  localparam logic [CNT_W-1:0] HI_MAX = CNT_W'({HI_W{1'b1}});
  localparam logic [CNT_W-1:0] LO_MAX = CNT_W'({LO_W{1'b1}});
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic s, rise, fall;

  meas_state_e     state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [HI_W-1:0]  hi_tmp_q, hi_tmp_n;
  logic [HI_W-1:0]  hi_count_q, hi_count_n;
  logic [LO_W-1:0]  lo_count_q, lo_count_n;
  logic             valid_q, valid_n;
  logic             stuck_hi_q, stuck_hi_n;
  logic             stuck_lo_q, stuck_lo_n;

  sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bus.sig_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARM;
      cnt_q      <= '0;
      hi_tmp_q   <= '0;
      hi_count_q <= '0;
      lo_count_q <= '0;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      hi_tmp_q   <= hi_tmp_n;
      hi_count_q <= hi_count_n;
      lo_count_q <= lo_count_n;
      valid_q    <= valid_n;
      stuck_hi_q <= stuck_hi_n;
      stuck_lo_q <= stuck_lo_n;
    end
  end

  // Next-state and measurement logic; disable overrides everything.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    hi_tmp_n   = hi_tmp_q;
    hi_count_n = hi_count_q;
    lo_count_n = lo_count_q;
    valid_n    = 1'b0;
    stuck_hi_n = stuck_hi_q;
    stuck_lo_n = stuck_lo_q;

    if (!bus.meas_en) begin
      state_n = ARM;
      cnt_n   = '0;
    end else begin
      unique case (state_q)
        ARM: begin
          // A level already in progress is partial, so wait for a real rise.
          if (rise) begin
            cnt_n   = ONE;
            state_n = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_tmp_n = cnt_q[HI_W-1:0];
            cnt_n    = ONE;
            state_n  = LOW;
          end else if (s && (cnt_q == HI_MAX)) begin
            stuck_hi_n = 1'b1;
            cnt_n      = '0;
            state_n    = ARM;
          end else if (s) begin
            cnt_n = cnt_q + ONE;
          end
        end
        LOW: begin
          if (rise) begin
            hi_count_n = hi_tmp_q;
            lo_count_n = cnt_q[LO_W-1:0];
            valid_n    = 1'b1;
            stuck_hi_n = 1'b0;
            stuck_lo_n = 1'b0;
            cnt_n      = ONE;
            state_n    = HIGH;
          end else if (!s && (cnt_q == LO_MAX)) begin
            stuck_lo_n = 1'b1;
            cnt_n      = '0;
            state_n    = ARM;
          end else if (!s) begin
            cnt_n = cnt_q + ONE;
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = ARM;
        end
      endcase
    end
  end

  assign bus.hi_count   = hi_count_q;
  assign bus.lo_count   = lo_count_q;
  assign bus.meas_valid = valid_q;
  assign bus.stuck_hi   = stuck_hi_q;
  assign bus.stuck_lo   = stuck_lo_q;
  assign bus.level      = s;

endmodule

// File: tb/tb_sqwave_meas.sv
// Bench for sqwave_meas: directed and random waveforms against a run-length model.
`timescale 1ns/1ps
module tb_sqwave_meas;
  import sqwave_pkg::*;

  localparam int unsigned HI_MAX = (1 << HI_W_DEF) - 1;
  localparam int unsigned LO_MAX = (1 << LO_W_DEF) - 1;

  logic clk = 1'b0;
  logic reset;

  sqwave_meas_if #(.HI_W(HI_W_DEF), .LO_W(LO_W_DEF)) bus ();

  sqwave_meas #(
    .HI_W(HI_W_DEF), .LO_W(LO_W_DEF), .SYNC_STAGES(SYNC_STAGES_DEF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Measurements seen on the DUT and expected by the model, per run list.
  int unsigned got_hi[$], got_lo[$];
  int unsigned exp_hi[$], exp_lo[$];
  int unsigned done_n = 0;

  // Driven waveform as merged runs since the last restart.
  logic        run_lvl[$];
  int unsigned run_len[$];
  logic        cur_lvl   = 1'b0;
  bit          first_cont = 1'b0;
  bit          recording = 1'b0;

  // Model state at list start and derived after each evaluation.
  bit          sh0 = 1'b0, sl0 = 1'b0;
  int unsigned last_hi0 = 0, last_lo0 = 0;
  bit          exp_sh, exp_sl;
  int unsigned last_hi, last_lo;

  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Capture every meas_valid pulse; a pulse never lasts two cycles.
  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) begin
      got_hi.push_back(32'(bus.hi_count));
      got_lo.push_back(32'(bus.lo_count));
      check("valid_pulse_width", 32'(prev_valid), 32'd0);
    end
    prev_valid = bus.meas_valid;
  end

  // Drive a level for n cycles, recording it into the run list.
  task automatic run(input logic v, input int unsigned n);
    if (recording) begin
      if (run_lvl.size() == 0) begin
        first_cont = (v == cur_lvl);
        run_lvl.push_back(v);
        run_len.push_back(n);
      end else if (run_lvl[run_lvl.size()-1] == v) begin
        run_len[run_len.size()-1] = run_len[run_len.size()-1] + n;
      end else begin
        run_lvl.push_back(v);
        run_len.push_back(n);
      end
    end
    cur_lvl    = v;
    bus.sig_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Derive expected measurements and flags from whole high/low runs.
  task automatic evaluate();
    bit          armed = 1'b0;
    bit          pend  = 1'b0;
    int unsigned ch = 0, ph = 0, pl = 0;
    exp_hi.delete();
    exp_lo.delete();
    exp_sh  = sh0;
    exp_sl  = sl0;
    last_hi = last_hi0;
    last_lo = last_lo0;
    for (int k = 0; k < run_lvl.size(); k++) begin
      if (run_lvl[k]) begin
        if (pend) begin
          exp_hi.push_back(ph);
          exp_lo.push_back(pl);
          last_hi = ph;
          last_lo = pl;
          exp_sh  = 1'b0;
          exp_sl  = 1'b0;
          pend    = 1'b0;
        end
        if (k == 0 && first_cont) begin
          armed = 1'b0;
        end else if (run_len[k] > HI_MAX) begin
          exp_sh = 1'b1;
          armed  = 1'b0;
        end else begin
          armed = 1'b1;
          ch    = run_len[k];
        end
      end else if (armed) begin
        if (run_len[k] > LO_MAX) begin
          exp_sl = 1'b1;
        end else begin
          pend = 1'b1;
          ph   = ch;
          pl   = run_len[k];
        end
        armed = 1'b0;
      end
    end
  endtask

  // Compare newly produced measurements and current flags with the model.
  task automatic flush(input string tag);
    int unsigned n;
    evaluate();
    check({tag, "_n_meas"}, 32'(got_hi.size()), 32'(exp_hi.size()));
    n = (got_hi.size() < exp_hi.size()) ? got_hi.size() : exp_hi.size();
    for (int unsigned i = done_n; i < n; i++) begin
      check({tag, "_hi"}, got_hi[i], exp_hi[i]);
      check({tag, "_lo"}, got_lo[i], exp_lo[i]);
    end
    done_n = n;
    check({tag, "_stuck_hi"}, 32'(bus.stuck_hi), 32'(exp_sh));
    check({tag, "_stuck_lo"}, 32'(bus.stuck_lo), 32'(exp_sl));
    check({tag, "_hi_count"}, 32'(bus.hi_count), last_hi);
    check({tag, "_lo_count"}, 32'(bus.lo_count), last_lo);
  endtask

  // Start a fresh run list after the DUT has been forced back to ARM.
  task automatic restart();
    run_lvl.delete();
    run_len.delete();
    got_hi.delete();
    got_lo.delete();
    done_n   = 0;
    sh0      = exp_sh;
    sl0      = exp_sl;
    last_hi0 = last_hi;
    last_lo0 = last_lo;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hi_count"},   32'(bus.hi_count),   32'd0);
    check({tag, "_lo_count"},   32'(bus.lo_count),   32'd0);
    check({tag, "_meas_valid"}, 32'(bus.meas_valid), 32'd0);
    check({tag, "_stuck_hi"},   32'(bus.stuck_hi),   32'd0);
    check({tag, "_stuck_lo"},   32'(bus.stuck_lo),   32'd0);
    check({tag, "_level"},      32'(bus.level),      32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.sig_in  = 1'b0;
    bus.meas_en = 1'b1;
    exp_sh = 1'b0; exp_sl = 1'b0; last_hi = 0; last_lo = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset     = 1'b0;
    recording = 1'b1;

    // 5/3 wave
    run(1'b0, 10);
    repeat (6) begin run(1'b1, 5); run(1'b0, 3); end
    run(1'b1, 12);
    flush("w5_3");

    // Minimum 1/1 wave, back-to-back valids
    run(1'b0, 10);
    repeat (10) begin run(1'b1, 1); run(1'b0, 1); end
    run(1'b1, 12);
    flush("w1_1");

    // Random periods
    repeat (30) begin
      run(1'b1, $urandom_range(40, 1));
      run(1'b0, $urandom_range(40, 1));
    end
    run(1'b1, 12);
    flush("rand");

    // Low held past the low-counter limit, then recovery
    run(1'b0, 2000);
    flush("stuck_lo");
    run(1'b1, 7); run(1'b0, 9); run(1'b1, 12);
    flush("after_lo");

    // High held past the high-counter limit, then a 10/20 wave
    run(1'b0, 10);
    run(1'b1, 66000);
    flush("stuck_hi");
    check("stuck_hi_level", 32'(bus.level), 32'd1);
    run(1'b0, 20);
    repeat (2) begin run(1'b1, 10); run(1'b0, 20); end
    run(1'b1, 12);
    flush("after_hi");

    // Reset in the middle of a high level of a 100/100 wave
    run(1'b0, 100); run(1'b1, 100); run(1'b0, 100); run(1'b1, 40);
    flush("pre_reset");
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    recording = 1'b0;
    run(1'b1, 60);
    run(1'b0, 5);
    reset  = 1'b0;
    exp_sh = 1'b0; exp_sl = 1'b0; last_hi = 0; last_lo = 0;
    restart();
    recording = 1'b1;
    run(1'b0, 100); run(1'b1, 100); run(1'b0, 100); run(1'b1, 20);
    flush("post_reset");

    // Disable mid-period for 50 cycles
    repeat (3) begin run(1'b1, 6); run(1'b0, 4); end
    run(1'b1, 30);
    flush("pre_dis");
    recording   = 1'b0;
    bus.meas_en = 1'b0;
    restart();
    run(1'b1, 20); run(1'b0, 20); run(1'b1, 10);
    check("dis_n_meas", 32'(got_hi.size()), 32'd0);
    check("dis_hold_hi", 32'(bus.hi_count), 32'd6);
    check("dis_hold_lo", 32'(bus.lo_count), 32'd4);
    bus.meas_en = 1'b1;
    recording   = 1'b1;
    run(1'b1, 15);
    run(1'b0, 8); run(1'b1, 3); run(1'b0, 8); run(1'b1, 3); run(1'b0, 8);
    run(1'b1, 12);
    flush("post_dis");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
